// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding, port ids, counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner selection; on a tie the port not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt_c
);

  always_comb begin
    gnt_c = PORT0;
    if (valid0_i && valid1_i) begin
      gnt_c = (last_i == PORT1) ? PORT0 : PORT1;
    end else if (valid1_i) begin
      gnt_c = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory port between two requesters (IDLE -> ISSUE -> RESP).
// Optional grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      gnt_cnt0_o,
  output logic [CNT_W-1:0]      gnt_cnt1_o
`endif
);

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  ready0_q, ready0_d;
  logic                  ready1_q, ready1_d;
  logic [WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [WIDTH-1:0]      rdata1_q, rdata1_d;
  logic                  win_c;
`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0]      cnt0_q, cnt0_d;
  logic [CNT_W-1:0]      cnt1_q, cnt1_d;
`endif

  rr_arb2 u_rr_arb2 (
    .valid0_i (req0_valid_i),
    .valid1_i (req1_valid_i),
    .last_i   (last_q),
    .gnt_c    (win_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef MEM_ARB_STATS_EN
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          gnt_d       = win_c;
          mem_wr_rd_d = (win_c == PORT1) ? req1_wr_rd_i : req0_wr_rd_i;
          mem_addr_d  = (win_c == PORT1) ? req1_addr_i  : req0_addr_i;
          mem_wdata_d = (win_c == PORT1) ? req1_wdata_i : req0_wdata_i;
          mem_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          mem_valid_d = 1'b0;
          last_d      = gnt_q;
          state_d     = RESP;
          if (gnt_q == PORT1) begin
            ready1_d = 1'b1;
            if (!mem_wr_rd_q) rdata1_d = mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
`endif
          end else begin
            ready0_d = 1'b1;
            if (!mem_wr_rd_q) rdata0_d = mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
`endif
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      gnt_q       <= PORT0;
      last_q      <= PORT1;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef MEM_ARB_STATS_EN
      cnt0_q      <= '0;
      cnt1_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef MEM_ARB_STATS_EN
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
`endif
    end
  end

  assign req0_ready_o = ready0_q;
  assign req1_ready_o = ready1_q;
  assign req0_rdata_o = rdata0_q;
  assign req1_rdata_o = rdata1_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_wr_rd_o  = mem_wr_rd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
`ifdef MEM_ARB_STATS_EN
  assign gnt_cnt0_o   = cnt0_q;
  assign gnt_cnt1_o   = cnt1_q;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of memory words.
REQ-002 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk_i  input  1  rising-edge clock.
REQ-005 rst_n_i  input  1  synchronous active-low reset.
REQ-006 req0_valid_i / req1_valid_i  input  1  request pending, per port.
REQ-007 req0_wr_rd_i / req1_wr_rd_i  input  1  1 = write, 0 = read.
REQ-008 req0_addr_i / req1_addr_i  input  ADDR_WIDTH  word address.
REQ-009 req0_wdata_i / req1_wdata_i  input  WIDTH  write data.
REQ-010 req0_ready_o / req1_ready_o  output  1  one-cycle completion pulse.
REQ-011 req0_rdata_o / req1_rdata_o  output  WIDTH  registered read data, per port.
REQ-012 mem_valid_o, mem_wr_rd_o  output  1 each  memory command valid and direction.
REQ-013 mem_addr_o  output  ADDR_WIDTH; mem_wdata_o  output  WIDTH; memory command fields.
REQ-014 mem_ready_i  input  1; mem_rdata_i  input  WIDTH; memory completion and read data.

Function
REQ-015 SHALL share one valid/ready memory port between two requesters with FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: if any reqN_valid_i = 1, select a winner, register its wr_rd/addr/wdata into the command registers, latch grant id, and go to ISSUE next edge; otherwise stay in IDLE.
REQ-017 Both valid in IDLE: the port not granted last SHALL win (round-robin); the last-grant pointer SHALL reset to 1, so port 0 wins the first tie.
REQ-018 ISSUE: mem_valid_o = 1 with registered fields stable; when mem_ready_i = 1, go to RESP; for a read, capture mem_rdata_i into the granted port's rdata_o on that edge.
REQ-019 RESP: the granted port's ready_o SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE; mem_valid_o = 0.
REQ-020 A requester SHALL hold valid and its fields until its ready_o cycle, and SHALL change or drop them only after that edge.
REQ-021 reqN_rdata_o SHALL hold its value until the next read completes on the same port; writes SHALL NOT alter it.
REQ-022 The last-grant pointer SHALL update only on entry to RESP.
REQ-023 Minimum latency SHALL be: request sampled at edge E, mem_valid_o at E+1, ready_o at E+2 when mem_ready_i is already 1, giving one transaction per 3 cycles.
REQ-024 A valid dropping while not granted SHALL be ignored; a valid dropping while granted SHALL NOT abort the command.
REQ-025 mem_ready_i outside ISSUE SHALL be ignored.

Reset
REQ-026 With rst_n_i = 0 at a rising edge: FSM goes to IDLE; all ready_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o and rdata_o go to 0; the pointer goes to 1.
REQ-027 Reset during ISSUE or RESP SHALL drop the in-flight command with no ready_o pulse.

Configuration
REQ-028 Macro MEM_ARB_STATS_EN defined: the block SHALL add outputs gnt_cnt0_o and gnt_cnt1_o (16 bits each), incremented on entry to RESP for that port, saturating at 16'hFFFF, and cleared by reset.
REQ-029 Macro undefined: these ports and counters SHALL NOT exist, and arbitration behaviour SHALL be identical.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the port-id constants PORT0/PORT1 and the counter width 16.
REQ-031 Sub-module rr_arb2 SHALL hold the two-way round-robin winner selection (inputs: two valids and the pointer; output: grant id).

Verification
REQ-032 Port 0 writes addr 3, data 16'hABCD, then reads addr 3 (mem ready tied high) -> req0_ready_o pulses at E+2 each time; req0_rdata_o = 16'hABCD.
REQ-033 Both ports valid continuously with different addresses -> grants alternate 0,1,0,1; with MEM_ARB_STATS_EN, counters equal 2/2 after 4 transactions.
REQ-034 mem_ready_i held low 5 cycles in ISSUE -> mem_valid_o stays 1 with stable fields, and no ready_o pulse until ready.
REQ-035 rst_n_i = 0 during ISSUE -> next cycle all outputs are 0 and no ready_o pulse; a later port-0 request completes normally.
REQ-036 Port 1 read of addr 15 returns 16'h1234 -> req1_rdata_o = 16'h1234, req0_rdata_o unchanged; a subsequent port 1 write leaves req1_rdata_o = 16'h1234.
